// File: rtl/feather_pkg.sv
`default_nettype none
// ============================================================================
// Module   : feather_pkg
// Purpose  : Shared types and constants for the load/store-multiple sequencer.
// Revision : 1.0  initial release
// ============================================================================
package feather_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } ldm_state_t;

  localparam int WORD_BYTES = 4;

  typedef logic [3:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/reg_list_scan.sv
`default_nettype none
// ============================================================================
// Module   : reg_list_scan
// Purpose  : Combinational scan of a 16-bit register list: lowest set index,
//            any-set flag and population count.
// Revision : 1.0  initial release
// ============================================================================
module reg_list_scan
  import feather_pkg::*;
(
  input  logic [15:0] list_i,
  output reg_idx_t    idx_o,
  output logic        any_o,
  output logic [4:0]  cnt_o
);

  always_comb begin
    idx_o = '0;
    cnt_o = '0;
    // Walk downward so the lowest set bit is the last one to overwrite idx_o.
    for (int k = 15; k >= 0; k--) begin
      if (list_i[k]) begin
        idx_o = reg_idx_t'(k);
      end
      cnt_o = cnt_o + 5'(list_i[k]);
    end
  end

  assign any_o = |list_i;

endmodule
`default_nettype wire

// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ldm_stm_sequencer
// Purpose  : Load/store-multiple sequencer; walks a register list issuing one
//            word beat per register. Base writeback needs LDM_STM_WRITEBACK_EN.
// Revision : 1.0  initial release
// ============================================================================
module ldm_stm_sequencer
  import feather_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         is_load_i,
  input  logic [15:0]  reg_list_i,
  input  logic [3:0]   base_reg_i,
  input  logic [N-1:0] base_addr_i,
  input  logic         up_i,
  input  logic         pre_i,
  input  logic         writeback_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [3:0]   rf_rd_addr_o,
  input  logic [N-1:0] rf_rd_data_i,
  output logic [3:0]   rf_wr_addr_o,
  output logic [N-1:0] rf_wr_data_o,
  output logic         rf_we_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_wdata_o,
  input  logic         mem_ready_i,
  input  logic [N-1:0] mem_rdata_i
);

  ldm_state_t   state_q, state_d;
  logic [15:0]  list_q, list_d;
  logic [N-1:0] addr_q, addr_d;
  logic         is_load_q, is_load_d;

  logic [15:0]  w_scan_list;
  reg_idx_t     w_idx;
  logic         w_any;
  logic [4:0]   w_cnt;
  logic [N-1:0] w_off;
  logic [N-1:0] w_start;

  // In IDLE the scanner sizes the incoming list; afterwards it picks the next register.
  assign w_scan_list = (state_q == IDLE) ? reg_list_i : list_q;

  reg_list_scan u_scan (
    .list_i (w_scan_list),
    .idx_o  (w_idx),
    .any_o  (w_any),
    .cnt_o  (w_cnt)
  );

  assign w_off = N'({w_cnt, 2'b00});

  always_comb begin
    case ({up_i, pre_i})
      2'b10:   w_start = base_addr_i;
      2'b11:   w_start = base_addr_i + N'(WORD_BYTES);
      2'b00:   w_start = base_addr_i - w_off + N'(WORD_BYTES);
      default: w_start = base_addr_i - w_off;
    endcase
  end

`ifdef LDM_STM_WRITEBACK_EN
  logic [N-1:0] final_q, final_d;
  reg_idx_t     base_reg_q, base_reg_d;
  logic         wb_q, wb_d;
  logic [N-1:0] w_final;

  assign w_final = up_i ? (base_addr_i + w_off) : (base_addr_i - w_off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      final_q    <= '0;
      base_reg_q <= '0;
      wb_q       <= 1'b0;
    end else begin
      final_q    <= final_d;
      base_reg_q <= base_reg_d;
      wb_q       <= wb_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = writeback_i ^ (^base_reg_i);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      list_q    <= '0;
      addr_q    <= '0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      list_q    <= list_d;
      addr_q    <= addr_d;
      is_load_q <= is_load_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    list_d       = list_q;
    addr_d       = addr_q;
    is_load_d    = is_load_q;
`ifdef LDM_STM_WRITEBACK_EN
    final_d      = final_q;
    base_reg_d   = base_reg_q;
    wb_d         = wb_q;
`endif
    done_o       = 1'b0;
    rf_rd_addr_o = '0;
    rf_wr_addr_o = '0;
    rf_wr_data_o = '0;
    rf_we_o      = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (w_any) begin
            state_d   = XFER;
            list_d    = reg_list_i;
            addr_d    = w_start;
            is_load_d = is_load_i;
`ifdef LDM_STM_WRITEBACK_EN
            final_d    = w_final;
            base_reg_d = base_reg_i;
            // A load that overwrites the base register keeps the loaded value.
            wb_d       = writeback_i & ~(is_load_i & reg_list_i[base_reg_i]);
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
      XFER: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        mem_we_o   = ~is_load_q;
        if (is_load_q) begin
          rf_we_o      = mem_ready_i;
          rf_wr_addr_o = w_idx;
          rf_wr_data_o = mem_rdata_i;
        end else begin
          rf_rd_addr_o = w_idx;
          mem_wdata_o  = rf_rd_data_i;
        end
        if (mem_ready_i) begin
          list_d = list_q & (list_q - 16'd1);
          addr_d = addr_q + N'(WORD_BYTES);
          if (list_d == 16'd0) begin
`ifdef LDM_STM_WRITEBACK_EN
            state_d = wb_q ? WB : DONE;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef LDM_STM_WRITEBACK_EN
      WB: begin
        rf_we_o      = 1'b1;
        rf_wr_addr_o = base_reg_q;
        rf_wr_data_o = final_q;
        state_d      = DONE;
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-register transfer sequencer for the core's 16-entry register file. It takes one load/store-multiple request: a 16-bit register list, a base address and an addressing mode. It then walks the list in ascending register order, issuing one word access per register on the data-memory port and driving the register-file read or write port for each beat. Optionally it finishes with a base-register writeback. It sits between decode/execute and the register file, and owns the register-file ports while busy.

## Interface
Parameters:
- N, 32, data and address width in bits

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  request strobe; sampled only in IDLE
- is_load_i  in  1  1 = load multiple (memory→registers), 0 = store multiple
- reg_list_i  in  16  bit k set ⇒ register k transferred
- base_reg_i  in  4  index of the base register
- base_addr_i  in  N  current value of the base register
- up_i  in  1  1 = increment addressing, 0 = decrement
- pre_i  in  1  1 = adjust address before the access (IB/DB), 0 = after (IA/DA)
- writeback_i  in  1  write the final address back to the base register
- busy_o  out  1  sequencer owns the register-file port
- done_o  out  1  one-cycle completion pulse
- rf_rd_addr_o  out  4  register-file read address (store data source)
- rf_rd_data_i  in  N  register-file read data for rf_rd_addr_o (combinational)
- rf_wr_addr_o  out  4  register-file write address
- rf_wr_data_o  out  N  register-file write data
- rf_we_o  out  1  register-file write enable
- mem_req_o  out  1  memory beat request
- mem_we_o  out  1  1 = memory write
- mem_addr_o  out  N  word address, byte-granular, always 4-aligned relative to the base
- mem_wdata_o  out  N  store data (= rf_rd_data_i)
- mem_ready_i  in  1  beat accepted on this edge when mem_req_o=1
- mem_rdata_i  in  N  load data, valid when mem_req_o & mem_ready_i

## Operation
- States: IDLE, XFER, WB, DONE.
- IDLE → XFER on start_i with a non-empty list. The block latches the list, mode, base register and is_load, and computes cnt = popcount(list), which is 1..16.
- IDLE → DONE on start_i with an empty list. No beats and no writeback occur.
- Start address:
  - IA: base
  - IB: base+4
  - DA: base−4·cnt+4
  - DB: base−4·cnt
- Beat addresses ascend by 4 in every mode.
- Final address: base+4·cnt when up_i=1, base−4·cnt when up_i=0. Arithmetic is modulo 2^N and wraps silently.
- XFER behaviour:
  - Current register = lowest set bit of the remaining list.
  - mem_req_o=1 and mem_addr_o = current address.
  - Store: rf_rd_addr_o = current register; mem_wdata_o = rf_rd_data_i.
  - Load: rf_we_o = mem_ready_i; rf_wr_addr_o = current register; rf_wr_data_o = mem_rdata_i. The write is combinational in the accepting cycle.
  - On each accepted beat: clear the current bit and add 4 to the address.
  - When the last bit clears: go to WB if writeback is enabled and permitted, otherwise go to DONE.
- WB (one cycle): rf_we_o=1, rf_wr_addr_o = base_reg, rf_wr_data_o = final address.
- Writeback is suppressed for a load whose list contains base_reg; the loaded value wins.
- Store of base_reg stores the original base value, because writeback happens after all beats.
- Load of r15 is a normal write to address 15; the register file resolves PC priority.
- DONE: done_o=1 for one cycle, then IDLE.
- start_i outside IDLE is ignored.
- Output flags: busy_o = (state ≠ IDLE); mem_we_o = ~is_load while in XFER.

## Timing
- Reset state: IDLE. While in reset, every output is 0: busy_o, done_o, mem_req_o, mem_we_o, rf_we_o, all address fields and all data fields.
- Asserting rst_n low mid-transfer aborts at once; a beat in flight is dropped.
- Start accepted at edge 0 → mem_req_o high from cycle 1.
- mem_req_o, mem_addr_o and mem_we_o are held stable until mem_ready_i is sampled high.
- Zero-wait latency, from start edge to done_o:
  - cnt beats, then DONE in cycle cnt+1.
  - With WB, DONE moves to cycle cnt+2.
- Empty list: done_o in cycle 1.

## Configuration
- LDM_STM_WRITEBACK_EN defined: the WB state and the suppression rule are present.
- LDM_STM_WRITEBACK_EN undefined: writeback_i is ignored, WB is never entered, and the final-address adder may be removed. The last beat always goes to DONE.

## Structure
- Shared package feather_pkg holds:
  - the state enum ldm_state_t (IDLE, XFER, WB, DONE)
  - the constant WORD_BYTES = 4
  - the register-index typedef reg_idx_t (logic [3:0])
- Sub-module reg_list_scan (combinational): 16-bit list in → lowest-set-bit index, any-set flag and popcount out.

## Test plan
- IA store, base 0x1000, list 0x0005, zero-wait:
  - beat 1: addr 0x1000, rf_rd_addr 0
  - beat 2: addr 0x1004, rf_rd_addr 2
  - done_o in cycle 3
- DB load with writeback, base 0x2000, list 0x8003, rdata A/B/C:
  - writes r0=A @0x1FF4, r1=B @0x1FF8, r15=C @0x1FFC
  - WB writes base_reg = 0x1FF4, then done_o
- Wait states: IB load of list 0x0010, mem_ready_i low for 3 cycles.
  - mem_addr_o stays base+4 throughout.
  - rf_we_o is asserted only in the ready cycle.
- Base in load list: base_reg=3, list 0x0008, writeback_i=1.
  - r3 receives the memory data.
  - No WB cycle occurs.
- Empty list, and start_i pulsed while busy:
  - empty list: done_o in cycle 1, mem_req_o never asserted.
  - second start ignored.
- rst_n dropped during beat 2 of 4:
  - all outputs 0 immediately, state IDLE.
  - a new start after reset release runs cleanly.
